// File: rtl/bus_region_router.sv
// bus_region_router
//   Routes load/store requests from the core to one of NUM_REGIONS memory-mapped
//   targets. Each target owns an inclusive [base, limit] window. Requests use a
//   valid/ready handshake. Targets finish with a per-region ack, and the router
//   returns a registered, single-cycle response. Unmapped addresses and targets
//   that never ack (when TIMEOUT_CYCLES != 0) produce an error response.
//
// Ports
//   clock, reset_n              posedge clock, asynchronous active-low reset
//   req_valid/ready             request handshake; ready is high only in IDLE
//   req_address/write/wdata     request payload
//   resp_valid                  one-cycle response strobe
//   resp_rdata/error            response payload, held until the next response
//   region_sel                  one-hot target select, held through BUSY
//   region_address              request address minus the selected region's base
//   region_write/wdata          registered request write flag and data
//   region_rdata                packed per-region read data
//   region_ack                  per-region done; only the selected bit counts

// Per-region decode and return-path masking.
module bus_region_lane #(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE       = '0,
  parameter logic [ADDR_WIDTH-1:0] LIMIT      = '0
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  output logic                  hit,
  output logic [ADDR_WIDTH-1:0] offset,
  input  logic                  sel,
  input  logic                  ack,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  ack_m,
  output logic [DATA_WIDTH-1:0] rdata_m
);
  // base <= addr <= limit is the same as (addr - base) <= (limit - base) in
  // modulo arithmetic. This reuses the offset subtractor and avoids a compare
  // against a constant zero base.
  localparam logic [ADDR_WIDTH-1:0] SPAN = LIMIT - BASE;
  localparam bit                    LIVE = (LIMIT >= BASE);

  assign offset  = addr - BASE;
  assign hit     = LIVE && (offset <= SPAN);
  assign ack_m   = sel & ack;
  assign rdata_m = sel ? rdata : '0;
endmodule

module bus_region_router #(
  parameter int NUM_REGIONS    = 4,
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_BASE  = {32'h1000, 32'h100, 32'h50, 32'h0},
  parameter logic [NUM_REGIONS*ADDR_WIDTH-1:0] REGION_LIMIT = {32'h1fff, 32'h1ff, 32'hff, 32'h4f},
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                              clock,
  input  logic                              reset_n,
  input  logic                              req_valid,
  output logic                              req_ready,
  input  logic [ADDR_WIDTH-1:0]             req_address,
  input  logic                              req_write,
  input  logic [DATA_WIDTH-1:0]             req_wdata,
  output logic                              resp_valid,
  output logic [DATA_WIDTH-1:0]             resp_rdata,
  output logic                              resp_error,
  output logic [NUM_REGIONS-1:0]            region_sel,
  output logic [ADDR_WIDTH-1:0]             region_address,
  output logic                              region_write,
  output logic [DATA_WIDTH-1:0]             region_wdata,
  input  logic [NUM_REGIONS*DATA_WIDTH-1:0] region_rdata,
  input  logic [NUM_REGIONS-1:0]            region_ack
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  // The counter only has to reach TIMEOUT_CYCLES-1.
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] TO_LAST =
    CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  state_t                                  state, state_nxt;
  logic [CNT_W-1:0]                        cnt, cnt_nxt;
  logic [NUM_REGIONS-1:0]                  sel_nxt;
  logic [ADDR_WIDTH-1:0]                   addr_nxt;
  logic                                    wr_nxt;
  logic [DATA_WIDTH-1:0]                   wd_nxt, rdata_nxt;
  logic                                    err_nxt;

  logic [NUM_REGIONS-1:0]                  hit, first, ack_m;
  logic [NUM_REGIONS-1:0][ADDR_WIDTH-1:0]  offs;
  logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0]  rd_m;
  logic [ADDR_WIDTH-1:0]                   off_sel;
  logic [DATA_WIDTH-1:0]                   rdata_sel;
  logic                                    ack_hit;

  for (genvar g = 0; g < NUM_REGIONS; g++) begin : g_lane
    bus_region_lane #(
      .ADDR_WIDTH (ADDR_WIDTH),
      .DATA_WIDTH (DATA_WIDTH),
      .BASE       (REGION_BASE[g*ADDR_WIDTH +: ADDR_WIDTH]),
      .LIMIT      (REGION_LIMIT[g*ADDR_WIDTH +: ADDR_WIDTH])
    ) u_lane (
      .addr    (req_address),
      .hit     (hit[g]),
      .offset  (offs[g]),
      .sel     (region_sel[g]),
      .ack     (region_ack[g]),
      .rdata   (region_rdata[g*DATA_WIDTH +: DATA_WIDTH]),
      .ack_m   (ack_m[g]),
      .rdata_m (rd_m[g])
    );
  end

  // Lowest-index hit wins on overlapping windows. Isolate the lowest set bit.
  assign first = hit & (~hit + NUM_REGIONS'(1));

  // Both vectors are one-hot or zero, so AND-OR muxing is enough.
  always_comb begin
    off_sel   = '0;
    rdata_sel = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      if (first[i]) off_sel = off_sel | offs[i];
      rdata_sel = rdata_sel | rd_m[i];
    end
    ack_hit = |ack_m;
  end

  always_comb begin
    state_nxt  = state;
    cnt_nxt    = cnt;
    sel_nxt    = region_sel;
    addr_nxt   = region_address;
    wr_nxt     = region_write;
    wd_nxt     = region_wdata;
    rdata_nxt  = resp_rdata;
    err_nxt    = resp_error;
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (|hit) begin
            sel_nxt   = first;
            addr_nxt  = off_sel;
            wr_nxt    = req_write;
            wd_nxt    = req_wdata;
            cnt_nxt   = '0;
            state_nxt = BUSY;
          end else begin
            err_nxt   = 1'b1;
            rdata_nxt = '0;
            state_nxt = RESP;
          end
        end
      end
      BUSY: begin
        cnt_nxt = cnt + CNT_W'(1);
        // An ack on the timeout edge still completes normally.
        if (ack_hit) begin
          rdata_nxt = region_write ? '0 : rdata_sel;
          err_nxt   = 1'b0;
          sel_nxt   = '0;
          state_nxt = RESP;
        end else if (TIMEOUT_CYCLES != 0 && cnt == TO_LAST) begin
          rdata_nxt = '0;
          err_nxt   = 1'b1;
          sel_nxt   = '0;
          state_nxt = RESP;
        end
      end
      RESP: begin
        resp_valid = 1'b1;
        state_nxt  = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cnt            <= '0;
      region_sel     <= '0;
      region_address <= '0;
      region_write   <= 1'b0;
      region_wdata   <= '0;
      resp_rdata     <= '0;
      resp_error     <= 1'b0;
    end else begin
      cnt            <= cnt_nxt;
      region_sel     <= sel_nxt;
      region_address <= addr_nxt;
      region_write   <= wr_nxt;
      region_wdata   <= wd_nxt;
      resp_rdata     <= rdata_nxt;
      resp_error     <= err_nxt;
    end
  end
endmodule

// File: tb/tb_bus_region_router.sv
module tb_bus_region_router;
  localparam int NR = 4;
  localparam int T  = 8;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              req_valid, req_write;
  logic              req_ready;
  logic [31:0]       req_address, req_wdata;
  logic              resp_valid, resp_error, region_write;
  logic [31:0]       resp_rdata, region_address, region_wdata;
  logic [NR-1:0]     region_sel, region_ack;
  logic [NR*32-1:0]  region_rdata;

  int n_chk = 0, n_pass = 0, n_fail = 0;

  // Reference windows: region i = [BASE[i], LIM[i]], lowest index wins.
  int unsigned BASE[NR] = '{32'h0,  32'h50, 32'h100, 32'h1000};
  int unsigned LIM [NR] = '{32'h4f, 32'hff, 32'h1ff, 32'h1fff};
  int unsigned EDGES[10] = '{32'h4f, 32'h50, 32'hff, 32'h100, 32'h1ff,
                             32'h200, 32'hfff, 32'h1000, 32'h1fff, 32'h2000};

  bus_region_router #(.TIMEOUT_CYCLES(T)) dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_address(req_address),
    .req_write(req_write), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_error(resp_error),
    .region_sel(region_sel), .region_address(region_address),
    .region_write(region_write), .region_wdata(region_wdata),
    .region_rdata(region_rdata), .region_ack(region_ack)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void decode(input logic [31:0] a, output int idx, output logic [31:0] off);
    idx = -1;
    off = '0;
    for (int i = NR - 1; i >= 0; i--)
      if (a >= BASE[i] && a <= LIM[i]) begin
        idx = i;
        off = a - BASE[i];
      end
  endfunction

  // Entered just after a negedge with the DUT idle; returns the same way.
  // dly = edge after accept on which the target acks (0 = never).
  task automatic txn(input string tag, input logic [31:0] addr, input bit wr,
                     input logic [31:0] wd, input int dly, input logic [31:0] rd,
                     input bit stray, input bit hold, input logic [31:0] naddr);
    int          idx, last;
    logic [31:0] off, er;
    logic [3:0]  own;
    bit          err;
    decode(addr, idx, off);
    own = (idx >= 0) ? 4'(1 << idx) : 4'b0;
    chk({tag, ".ready"}, 64'(req_ready), 64'(1));
    req_valid    = 1'b1;
    req_address  = addr;
    req_write    = wr;
    req_wdata    = wd;
    region_rdata = {$urandom, $urandom, $urandom, $urandom};
    if (idx >= 0) region_rdata[idx*32 +: 32] = rd;
    region_ack   = stray ? 4'($urandom) : 4'b0;
    @(posedge clock);
    @(negedge clock);
    if (hold) begin
      req_address = naddr;
      req_write   = 1'b0;
    end else begin
      req_valid   = 1'b0;
      req_address = $urandom;
      req_write   = 1'($urandom);
      req_wdata   = $urandom;
    end
    if (idx < 0) begin
      err = 1'b1;
      er  = '0;
      chk({tag, ".miss_sel"}, 64'(region_sel), 64'(0));
    end else begin
      err  = (dly == 0 || dly > T);
      last = err ? T : dly;
      er   = (err || wr) ? 32'h0 : rd;
      for (int k = 1; k <= last; k++) begin
        chk({tag, ".sel"},    64'(region_sel),     64'(own));
        chk({tag, ".raddr"},  64'(region_address), 64'(off));
        chk({tag, ".rwrite"}, 64'(region_write),   64'(wr));
        chk({tag, ".rwdata"}, 64'(region_wdata),   64'(wd));
        chk({tag, ".busy_v"}, 64'(resp_valid),     64'(0));
        chk({tag, ".busy_r"}, 64'(req_ready),      64'(0));
        region_ack = stray ? (4'($urandom) & ~own) : 4'b0;
        if (k == dly) region_ack = region_ack | own;
        @(negedge clock);
      end
    end
    region_ack = stray ? 4'($urandom) : 4'b0;
    chk({tag, ".rvalid"}, 64'(resp_valid), 64'(1));
    chk({tag, ".rerr"},   64'(resp_error), 64'(err));
    chk({tag, ".rdata"},  64'(resp_rdata), 64'(er));
    chk({tag, ".rsel"},   64'(region_sel), 64'(0));
    chk({tag, ".rready"}, 64'(req_ready),  64'(0));
    @(negedge clock);
    chk({tag, ".post_v"},    64'(resp_valid), 64'(0));
    chk({tag, ".post_rdy"},  64'(req_ready),  64'(1));
    chk({tag, ".hold_data"}, 64'(resp_rdata), 64'(er));
    chk({tag, ".hold_err"},  64'(resp_error), 64'(err));
  endtask

  initial begin
    int          mode, dly;
    logic [31:0] a;
    reset_n      = 1'b0;
    req_valid    = 1'b0;
    req_address  = '0;
    req_write    = 1'b0;
    req_wdata    = '0;
    region_ack   = '0;
    region_rdata = '0;
    repeat (2) @(negedge clock);
    chk("rst.ready", 64'(req_ready),      64'(1));
    chk("rst.valid", 64'(resp_valid),     64'(0));
    chk("rst.rdata", 64'(resp_rdata),     64'(0));
    chk("rst.err",   64'(resp_error),     64'(0));
    chk("rst.sel",   64'(region_sel),     64'(0));
    chk("rst.addr",  64'(region_address), 64'(0));
    chk("rst.wr",    64'(region_write),   64'(0));
    chk("rst.wd",    64'(region_wdata),   64'(0));
    reset_n = 1'b1;
    @(negedge clock);

    txn("t1_read",  32'h54,  1'b0, 32'h0,        1, 32'hDEADBEEF, 1'b0, 1'b0, 32'h0);
    txn("t2_write", 32'h4f,  1'b1, 32'h12345678, 3, 32'hCAFEF00D, 1'b0, 1'b0, 32'h0);
    txn("t3_miss",  32'h200, 1'b0, 32'h0,        1, 32'h11111111, 1'b0, 1'b0, 32'h0);
    txn("t4_tmo",   32'h100, 1'b0, 32'h0,        0, 32'h22222222, 1'b0, 1'b0, 32'h0);
    txn("t4_ack_at_limit", 32'h100, 1'b0, 32'h0, T, 32'h33333333, 1'b0, 1'b0, 32'h0);

    // Reset while BUSY aborts with no response.
    req_valid   = 1'b1;
    req_address = 32'h100;
    req_write   = 1'b0;
    @(posedge clock);
    @(negedge clock);
    req_valid = 1'b0;
    chk("t5.sel_busy", 64'(region_sel), 64'(4'b0100));
    repeat (2) @(negedge clock);
    #2 reset_n = 1'b0;
    #1;
    chk("t5.sel_async", 64'(region_sel),     64'(0));
    chk("t5.rdy_async", 64'(req_ready),      64'(1));
    chk("t5.v_async",   64'(resp_valid),     64'(0));
    chk("t5.addr_async",64'(region_address), 64'(0));
    @(negedge clock);
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("t5.no_resp", 64'(resp_valid), 64'(0));
      chk("t5.ready",   64'(req_ready),  64'(1));
    end

    // Back-to-back requests with req_valid held and stray acks.
    txn("t6_a", 32'h50,   1'b0, 32'h0, 2, 32'hA5A5A5A5, 1'b1, 1'b1, 32'h1004);
    txn("t6_b", 32'h1004, 1'b0, 32'h0, 1, 32'h5A5A5A5A, 1'b1, 1'b0, 32'h0);

    for (int n = 0; n < 40; n++) begin
      mode = int'($urandom_range(0, 3));
      case (mode)
        0:       a = $urandom_range(0, 32'h2100);
        1:       a = $urandom;
        2:       a = EDGES[$urandom_range(0, 9)];
        default: a = $urandom_range(0, 32'h1ff);
      endcase
      dly = int'($urandom_range(0, 10));
      txn("rnd", a, 1'($urandom), $urandom, dly, $urandom, 1'($urandom), 1'b0, 32'h0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
